// File: rtl/cva6v_mem_port_arb_if.sv
// Bus bundle for the N:1 memory-port arbiter: per-input request/response pairs plus the merged memory port.
// Signal prefixes are from the arbiter's viewpoint; "slave" is the arbiter side, "master" drives it.
interface cva6v_mem_port_arb_if #(
    parameter int NumIn     = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 512
);
    localparam int BeWidth = (DataWidth + 7) / 8;

    logic [NumIn-1:0]                i_in_req_valid;
    logic [NumIn-1:0]                o_in_req_ready;
    logic [NumIn-1:0][AddrWidth-1:0] i_in_req_addr;
    logic [NumIn-1:0]                i_in_req_we;
    logic [NumIn-1:0][BeWidth-1:0]   i_in_req_be;
    logic [NumIn-1:0][DataWidth-1:0] i_in_req_wdata;
    logic [NumIn-1:0]                o_in_res_valid;
    logic [NumIn-1:0][DataWidth-1:0] o_in_res_rdata;
    logic [NumIn-1:0]                o_in_res_err;

    logic                 o_mem_req_valid;
    logic                 i_mem_req_ready;
    logic [AddrWidth-1:0] o_mem_req_addr;
    logic                 o_mem_req_we;
    logic [BeWidth-1:0]   o_mem_req_be;
    logic [DataWidth-1:0] o_mem_req_wdata;
    logic                 i_mem_res_valid;
    logic [DataWidth-1:0] i_mem_res_rdata;
    logic                 i_mem_res_err;

    modport slave (
        input  i_in_req_valid, i_in_req_addr, i_in_req_we, i_in_req_be, i_in_req_wdata,
        output o_in_req_ready, o_in_res_valid, o_in_res_rdata, o_in_res_err,
        output o_mem_req_valid, o_mem_req_addr, o_mem_req_we, o_mem_req_be, o_mem_req_wdata,
        input  i_mem_req_ready, i_mem_res_valid, i_mem_res_rdata, i_mem_res_err
    );

    modport master (
        output i_in_req_valid, i_in_req_addr, i_in_req_we, i_in_req_be, i_in_req_wdata,
        input  o_in_req_ready, o_in_res_valid, o_in_res_rdata, o_in_res_err,
        input  o_mem_req_valid, o_mem_req_addr, o_mem_req_we, o_mem_req_be, o_mem_req_wdata,
        output i_mem_req_ready, i_mem_res_valid, i_mem_res_rdata, i_mem_res_err
    );
endinterface

// File: rtl/cva6v_mem_port_arb.sv
// Round-robin N:1 memory-port arbiter with in-order response routing through an outstanding-index FIFO.
// Optional per-input grant and stall counters are built when CVA6V_MEM_PORT_ARB_PERF_EN is defined.
module cva6v_mem_port_arb #(
    parameter int  NumIn          = 4,
    parameter int  AddrWidth      = 32,
    parameter int  DataWidth      = 512,
    parameter int  MaxOutstanding = 8,
    localparam int BeWidth        = (DataWidth + 7) / 8,
    localparam int IdxW           = $clog2(NumIn),
    localparam int CntW           = $clog2(MaxOutstanding + 1),
    localparam int PtrW           = $clog2(MaxOutstanding)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    cva6v_mem_port_arb_if.slave       bus,
    output logic [CntW-1:0]           o_outstanding,
    output logic                      o_unexp_res
`ifdef CVA6V_MEM_PORT_ARB_PERF_EN
    ,
    output logic [NumIn-1:0][31:0]    o_perf_grant_cnt,
    output logic [31:0]               o_perf_stall_cnt
`endif
);

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            unexp_q;

    logic            any_v, full, empty, accept, pop;
    logic [IdxW-1:0] gnt, cand;

    assign full  = (cnt_q == CntW'(MaxOutstanding));
    assign empty = (cnt_q == '0);

    // Nothing is requested or routed while reset is asserted.
    always_comb begin
        any_v = i_rst_n && (|bus.i_in_req_valid);
        gnt   = rr_q;
        cand  = rr_q;
        for (int k = NumIn - 1; k >= 0; k--) begin
            cand = IdxW'((int'(rr_q) + k) % NumIn);
            if (bus.i_in_req_valid[cand]) gnt = cand;
        end
        // A stalled grant is held so the presented payload cannot switch under backpressure.
        if (lock_q && bus.i_in_req_valid[lock_idx_q]) gnt = lock_idx_q;
    end

    always_comb begin
        bus.o_mem_req_valid = any_v && !full;
        bus.o_in_req_ready  = '0;
        bus.o_mem_req_addr  = '0;
        bus.o_mem_req_we    = 1'b0;
        bus.o_mem_req_be    = '0;
        bus.o_mem_req_wdata = '0;
        if (any_v) begin
            bus.o_in_req_ready[gnt] = bus.i_mem_req_ready && !full;
            bus.o_mem_req_addr      = bus.i_in_req_addr[gnt];
            bus.o_mem_req_we        = bus.i_in_req_we[gnt];
            bus.o_mem_req_be        = bus.i_in_req_be[gnt];
            bus.o_mem_req_wdata     = bus.i_in_req_wdata[gnt];
        end
    end

    assign accept = bus.o_mem_req_valid && bus.i_mem_req_ready;
    assign pop    = i_rst_n && bus.i_mem_res_valid && !empty;

    always_comb begin
        bus.o_in_res_valid = '0;
        bus.o_in_res_err   = '0;
        if (pop) begin
            bus.o_in_res_valid[fifo_q[rd_q]] = 1'b1;
            bus.o_in_res_err[fifo_q[rd_q]]   = bus.i_mem_res_err;
        end
        for (int i = 0; i < NumIn; i++) begin
            bus.o_in_res_rdata[i] = (i_rst_n && bus.i_mem_res_valid) ? bus.i_mem_res_rdata : '0;
        end
    end

    always_comb begin
        rr_d  = rr_q;
        if (accept) rr_d = (int'(gnt) == NumIn - 1) ? '0 : gnt + 1'b1;
        cnt_d = cnt_q + CntW'(accept) - CntW'(pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            unexp_q    <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= bus.o_mem_req_valid && !bus.i_mem_req_ready;
            lock_idx_q <= gnt;
            cnt_q      <= cnt_d;
            if (accept) wr_q <= wr_q + 1'b1;
            if (pop)    rd_q <= rd_q + 1'b1;
            if (bus.i_mem_res_valid && empty) unexp_q <= 1'b1;
        end
    end

    // Index storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge i_clk) begin
        if (accept) fifo_q[wr_q] <= gnt;
    end

    assign o_outstanding = cnt_q;
    assign o_unexp_res   = unexp_q;

`ifdef CVA6V_MEM_PORT_ARB_PERF_EN
    logic [NumIn-1:0][31:0] grant_cnt_q;
    logic [31:0]            stall_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) grant_cnt_q[gnt] <= grant_cnt_q[gnt] + 32'd1;
            if ((bus.o_mem_req_valid && !bus.i_mem_req_ready) || (any_v && full))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_perf_grant_cnt = grant_cnt_q;
    assign o_perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/cva6v_mem_port_arb.md
Name: cva6v_mem_port_arb

Overview:
Parametrised N:1 arbiter for Raptor vector memory ports. It merges NumIn request/response port pairs onto one physical memory port. Requests are granted round-robin. Responses, which return in order, are routed back to the issuing input through an outstanding-transaction FIFO. It sits between cva6v_top memory ports and the TCDM interconnect, so the number of core ports can exceed the number of interconnect ports.

Parameters:
NumIn, 4, number of input request/response port pairs (>=2)
AddrWidth, 32, request address width
DataWidth, 512, data width; byte-enable width BeWidth = (DataWidth+7)/8 (derived)
MaxOutstanding, 8, outstanding-FIFO depth (>=2, power of two); IdxW = $clog2(NumIn) (derived)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_in_req_valid  in  NumIn  per-input request valid
o_in_req_ready  out  NumIn  per-input request ready
i_in_req_addr  in  NumIn x AddrWidth  request address
i_in_req_we  in  NumIn  write enable
i_in_req_be  in  NumIn x BeWidth  byte enables
i_in_req_wdata  in  NumIn x DataWidth  write data
o_in_res_valid  out  NumIn  per-input response valid
o_in_res_rdata  out  NumIn x DataWidth  response data (broadcast)
o_in_res_err  out  NumIn  response error
o_mem_req_valid  out  1  merged request valid
i_mem_req_ready  in  1  merged request ready
o_mem_req_addr / o_mem_req_we / o_mem_req_be / o_mem_req_wdata  out  AddrWidth/1/BeWidth/DataWidth  merged request payload
i_mem_res_valid  in  1  response valid (no backpressure)
i_mem_res_rdata  in  DataWidth  response data
i_mem_res_err  in  1  response error
o_outstanding  out  $clog2(MaxOutstanding+1)  in-flight count
o_unexp_res  out  1  sticky: response received with FIFO empty

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: RR pointer=0, FIFO empty, o_outstanding=0, o_unexp_res=0. All outputs are combinationally 0 when there are no valid inputs and no response.
- Grant selection:
  - Combinational. Search starts at the RR pointer and takes the first i with i_in_req_valid[i].
  - o_mem_req_valid = any valid && !fifo_full.
  - Payload is muxed from the granted input.
  - o_in_req_ready[g] = i_mem_req_ready && !fifo_full; all other readies are 0.
- Accept (o_mem_req_valid && i_mem_req_ready):
  - Push g into the FIFO.
  - RR pointer <= (g+1) mod NumIn. Wrap from NumIn-1 to 0.
  - The pointer holds when there is no accept.
- Stability: a granted input that is not accepted keeps its grant while it remains valid. The pointer does not move, so valid/payload stability (AXI-like) holds.
- Full FIFO:
  - Request side stalls. fifo_full is registered-state based only.
  - A same-cycle response pop does NOT unblock the request. There is no combinational path from i_mem_res_valid to any ready.
- Response, zero latency:
  - o_in_res_valid[head] = i_mem_res_valid. o_in_res_err[head] = i_mem_res_err.
  - rdata is broadcast to all inputs.
  - Pop on i_mem_res_valid.
- Empty FIFO with i_mem_res_valid: no o_in_res_valid is asserted, no pop, o_unexp_res <= 1 (sticky until reset).
- Simultaneous push and pop with FIFO non-full and non-empty: both occur; o_outstanding is unchanged.
- o_outstanding = FIFO occupancy, registered; range 0..MaxOutstanding.
- Reset mid-operation: FIFO and pointer are cleared immediately. In-flight responses after reset release are reported via o_unexp_res.
- Error responses are routed identically to data responses. The arbiter does not interpret errors.

Optional Feature:
CVA6V_MEM_PORT_ARB_PERF_EN
- Defined:
  - Adds output o_perf_grant_cnt (NumIn x 32): per-input accepted-request counters, wrapping at 2^32.
  - Adds output o_perf_stall_cnt (32): counts cycles with o_mem_req_valid && !i_mem_req_ready, plus cycles with any valid input while fifo_full.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. NumIn=4, all inputs valid every cycle, i_mem_req_ready=1, responses returned 3 cycles later -> grant order 0,1,2,3,0,...; each response asserts o_in_res_valid only on the matching input; o_outstanding peaks at 3.
2. Only input 2 valid, i_mem_req_ready=0 for 5 cycles then 1 -> o_mem_req_valid=1 throughout, payload stable, o_in_req_ready[2]=1 exactly on the accept cycle, pointer becomes 3.
3. 8 requests accepted with no responses (MaxOutstanding=8) -> o_outstanding=8; all readies 0; a response arriving that same cycle still gives no accept that cycle; the next request is accepted the following cycle.
4. i_mem_res_valid pulse with FIFO empty after reset -> all o_in_res_valid=0, o_unexp_res=1 and it stays 1.
5. Response with i_mem_res_err=1 for a request from input 1 -> o_in_res_err[1]=1 and o_in_res_valid[1]=1 in the same cycle; no other input is flagged.
6. Assert i_rst_n=0 with 4 outstanding -> o_outstanding=0 and o_mem_req_valid=0 immediately; after release, the first grant goes to input 0 when all inputs are valid.
